// File: rtl/priority_checker.sv
// priority_checker: registered passenger-class priority checker.
// Samples a VIP/Business/Regular request vector and reports, one clock
// later, whether the class chosen by sel is pending (or, in auto mode,
// whether anything is pending), the highest pending class, and a
// saturating count of cycles in which the check result was loaded with 1.
module priority_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [2:0]       priority_in,
    output logic             priority_out,
    output logic [1:0]       top_class,
    output logic             any_pending,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [1:0] CLASS_REGULAR  = 2'b00;
    localparam logic [1:0] CLASS_BUSINESS = 2'b01;
    localparam logic [1:0] CLASS_VIP      = 2'b10;
    localparam logic [1:0] CLASS_NONE     = 2'b11;

    // class_match[gi] is set when sel names class gi and that class has a
    // pending request; sel=11 (auto) never matches an individual class.
    logic [2:0]       class_match;

    logic             any_next;
    logic             priority_next;
    logic [1:0]       top_class_next;
    logic [CNT_W-1:0] hit_count_next;

    logic             priority_reg;
    logic [1:0]       top_class_reg;
    logic             any_reg;
    logic [CNT_W-1:0] hit_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_class_match
            assign class_match[gi] = (sel == gi[1:0]) && priority_in[gi];
        end
    endgenerate

    // Next-state logic: check result, fixed-priority class encode and the
    // saturating counter, all derived from the current input sample.
    always_comb begin
        any_next = |priority_in;

        priority_next = (sel == 2'b11) ? any_next : |class_match;

        if (priority_in[2])
            top_class_next = CLASS_VIP;
        else if (priority_in[1])
            top_class_next = CLASS_BUSINESS;
        else if (priority_in[0])
            top_class_next = CLASS_REGULAR;
        else
            top_class_next = CLASS_NONE;

        hit_count_next = hit_count_reg;
        if (priority_next && (hit_count_reg != {CNT_W{1'b1}}))
            hit_count_next = hit_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Output registers; synchronous reset takes precedence over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            priority_reg  <= 1'b0;
            top_class_reg <= CLASS_NONE;
            any_reg       <= 1'b0;
            hit_count_reg <= '0;
        end else begin
            priority_reg  <= priority_next;
            top_class_reg <= top_class_next;
            any_reg       <= any_next;
            hit_count_reg <= hit_count_next;
        end
    end

    assign priority_out = priority_reg;
    assign top_class    = top_class_reg;
    assign any_pending  = any_reg;
    assign hit_count    = hit_count_reg;

endmodule

// File: tb/tb_priority_checker.sv
// Testbench for priority_checker: table of directed vectors with
// hand-computed expectations, plus a counter saturation sequence.
module tb_priority_checker;

    localparam int CNT_W  = 8;
    localparam int N_VECS = 24;

    logic             clk;
    logic             rst;
    logic [1:0]       sel;
    logic [2:0]       priority_in;
    logic             priority_out;
    logic [1:0]       top_class;
    logic             any_pending;
    logic [CNT_W-1:0] hit_count;

    int checks;
    int errors;

    priority_checker #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .priority_in  (priority_in),
        .priority_out (priority_out),
        .top_class    (top_class),
        .any_pending  (any_pending),
        .hit_count    (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] sel;
        logic [2:0] pin;
        logic       exp_out;
        logic [1:0] exp_top;
        logic       exp_any;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [N_VECS];

    task automatic check(input string name, input int idx,
                         input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, actual, expected);
        end
    endtask

    // Drive one sample on the falling edge, then compare just after the rising edge.
    task automatic apply(input logic r, input logic [1:0] s, input logic [2:0] p);
        @(negedge clk);
        rst         = r;
        sel         = s;
        priority_in = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_cnt;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        sel = 2'b10;
        priority_in = 3'b111;

        // rst sel pin | out top any cnt
        vecs[0]  = '{1'b1, 2'b10, 3'b111, 1'b0, 2'b11, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 2'b10, 3'b111, 1'b0, 2'b11, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 2'b00, 3'b101, 1'b1, 2'b10, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 2'b01, 3'b101, 1'b0, 2'b10, 1'b1, 8'd1};
        vecs[4]  = '{1'b0, 2'b10, 3'b101, 1'b1, 2'b10, 1'b1, 8'd2};
        vecs[5]  = '{1'b0, 2'b11, 3'b000, 1'b0, 2'b11, 1'b0, 8'd2};
        vecs[6]  = '{1'b0, 2'b11, 3'b001, 1'b1, 2'b00, 1'b1, 8'd3};
        vecs[7]  = '{1'b0, 2'b11, 3'b010, 1'b1, 2'b01, 1'b1, 8'd4};
        vecs[8]  = '{1'b0, 2'b11, 3'b011, 1'b1, 2'b01, 1'b1, 8'd5};
        vecs[9]  = '{1'b0, 2'b11, 3'b100, 1'b1, 2'b10, 1'b1, 8'd6};
        vecs[10] = '{1'b0, 2'b00, 3'b000, 1'b0, 2'b11, 1'b0, 8'd6};
        vecs[11] = '{1'b0, 2'b01, 3'b000, 1'b0, 2'b11, 1'b0, 8'd6};
        vecs[12] = '{1'b0, 2'b10, 3'b000, 1'b0, 2'b11, 1'b0, 8'd6};
        vecs[13] = '{1'b0, 2'b11, 3'b000, 1'b0, 2'b11, 1'b0, 8'd6};
        vecs[14] = '{1'b0, 2'b00, 3'b110, 1'b0, 2'b10, 1'b1, 8'd6};
        vecs[15] = '{1'b0, 2'b01, 3'b011, 1'b1, 2'b01, 1'b1, 8'd7};
        vecs[16] = '{1'b1, 2'b11, 3'b111, 1'b0, 2'b11, 1'b0, 8'd0};
        vecs[17] = '{1'b0, 2'b11, 3'b111, 1'b1, 2'b10, 1'b1, 8'd1};
        vecs[18] = '{1'b0, 2'b11, 3'b111, 1'b1, 2'b10, 1'b1, 8'd2};
        vecs[19] = '{1'b0, 2'b11, 3'b111, 1'b1, 2'b10, 1'b1, 8'd3};
        vecs[20] = '{1'b0, 2'b11, 3'b111, 1'b1, 2'b10, 1'b1, 8'd4};
        vecs[21] = '{1'b0, 2'b11, 3'b111, 1'b1, 2'b10, 1'b1, 8'd5};
        vecs[22] = '{1'b1, 2'b11, 3'b111, 1'b0, 2'b11, 1'b0, 8'd0};
        vecs[23] = '{1'b0, 2'b11, 3'b001, 1'b1, 2'b00, 1'b1, 8'd1};

        for (int i = 0; i < N_VECS; i++) begin
            apply(vecs[i].rst, vecs[i].sel, vecs[i].pin);
            $display("vec %0d: rst=%b sel=%b pin=%b -> out=%b top=%b any=%b cnt=%0d",
                     i, vecs[i].rst, vecs[i].sel, vecs[i].pin,
                     priority_out, top_class, any_pending, hit_count);
            check("priority_out", i, 32'(priority_out), 32'(vecs[i].exp_out));
            check("top_class",    i, 32'(top_class),    32'(vecs[i].exp_top));
            check("any_pending",  i, 32'(any_pending),  32'(vecs[i].exp_any));
            check("hit_count",    i, 32'(hit_count),    32'(vecs[i].exp_cnt));
        end

        // Saturation: auto mode with everything pending for 300 cycles,
        // counter climbs from 1 to 255 and must hold there.
        exp_cnt = 8'd1;
        for (int c = 0; c < 300; c++) begin
            apply(1'b0, 2'b11, 3'b111);
            if (exp_cnt != 8'hFF)
                exp_cnt = exp_cnt + 8'd1;
            check("sat_hit_count", c, 32'(hit_count), 32'(exp_cnt));
        end
        $display("saturation: after 300 cycles hit_count=%0d", hit_count);

        // Idle cycle after saturation: no hit, count stays at 255.
        apply(1'b0, 2'b10, 3'b011);
        $display("post-sat idle: out=%b top=%b cnt=%0d", priority_out, top_class, hit_count);
        check("idle_priority_out", 0, 32'(priority_out), 32'd0);
        check("idle_top_class",    0, 32'(top_class),    32'd1);
        check("idle_hit_count",    0, 32'(hit_count),    32'd255);

        // One more hit at saturation must not wrap.
        apply(1'b0, 2'b00, 3'b001);
        $display("post-sat hit: out=%b cnt=%0d", priority_out, hit_count);
        check("nowrap_priority_out", 0, 32'(priority_out), 32'd1);
        check("nowrap_hit_count",    0, 32'(hit_count),    32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule
